// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared state, opcode and strobe index definitions for the ALU controller
package alu_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_LOAD_X   = 4'd1,
    ST_LOAD_Y   = 4'd2,
    ST_CHECK    = 4'd3,
    ST_EXEC     = 4'd4,
    ST_BOOTH_OP = 4'd5,
    ST_BOOTH_SH = 4'd6,
    ST_DIV_SH   = 4'd7,
    ST_DIV_OP   = 4'd8,
    ST_DIV_SETQ = 4'd9,
    ST_DIV_CORR = 4'd10,
    ST_OUT_A    = 4'd11,
    ST_OUT_Q    = 4'd12,
    ST_DONE     = 4'd13
  } state_e;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam int CTRL_W = 9;

  localparam logic [3:0] CTRL_LD_X  = 4'd0;
  localparam logic [3:0] CTRL_LD_Y  = 4'd1;
  localparam logic [3:0] CTRL_ADD   = 4'd2;
  localparam logic [3:0] CTRL_SUB   = 4'd3;
  localparam logic [3:0] CTRL_SHR   = 4'd4;
  localparam logic [3:0] CTRL_SHL   = 4'd5;
  localparam logic [3:0] CTRL_SETQ0 = 4'd6;
  localparam logic [3:0] CTRL_OUT_A = 4'd7;
  localparam logic [3:0] CTRL_OUT_Q = 4'd8;

endpackage

// File: rtl/alu_iter_counter.sv
// rtl/alu_iter_counter.sv - iteration counter for the Booth and non-restoring divide loops
module alu_iter_counter #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic last
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (inc) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // The loops exit on last, so the counter never wraps.
  assign last = (r_cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/alu_ctrl_param.sv
// rtl/alu_ctrl_param.sv - sequencer for the add/sub/Booth-multiply/non-restoring-divide ALU datapath
module alu_ctrl_param
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        s,
  input  logic              q0,
  input  logic              q_1,
  input  logic              a_msb,
  input  logic              m_zero,
  output logic [CTRL_W-1:0] ctrl,
  output logic              busy,
  output logic              finish,
  output logic              err
);

  state_e            r_state;
  logic [1:0]        r_op;
  logic              r_neg;
  logic              r_err;

  state_e            w_next;
  logic [CTRL_W-1:0] w_ctrl;
  logic              w_cnt_clr;
  logic              w_cnt_inc;
  logic              w_cnt_last;

  alu_iter_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_cnt_clr),
    .inc  (w_cnt_inc),
    .last (w_cnt_last)
  );

  always_comb begin
    w_next    = ST_IDLE;
    w_ctrl    = '0;
    w_cnt_clr = 1'b0;
    w_cnt_inc = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_next = start ? ST_LOAD_X : ST_IDLE;
      end
      ST_LOAD_X: begin
        w_ctrl[CTRL_LD_X] = 1'b1;
        w_next            = ST_LOAD_Y;
      end
      ST_LOAD_Y: begin
        w_ctrl[CTRL_LD_Y] = 1'b1;
        w_cnt_clr         = 1'b1;
        case (r_op)
          OP_MUL:  w_next = ST_BOOTH_OP;
          OP_DIV:  w_next = ST_CHECK;
          default: w_next = ST_EXEC;
        endcase
      end
      ST_CHECK: begin
        w_next = m_zero ? ST_DONE : ST_DIV_SH;
      end
      ST_EXEC: begin
        w_ctrl[CTRL_ADD] = (r_op == OP_ADD);
        w_ctrl[CTRL_SUB] = (r_op == OP_SUB);
        w_next           = ST_OUT_A;
      end
      ST_BOOTH_OP: begin
        // Booth recoding: 01 adds M, 10 subtracts M, 00/11 only shift.
        w_ctrl[CTRL_ADD] = ({q0, q_1} == 2'b01);
        w_ctrl[CTRL_SUB] = ({q0, q_1} == 2'b10);
        w_next           = ST_BOOTH_SH;
      end
      ST_BOOTH_SH: begin
        w_ctrl[CTRL_SHR] = 1'b1;
        if (w_cnt_last) begin
          w_next = ST_OUT_A;
        end else begin
          w_cnt_inc = 1'b1;
          w_next    = ST_BOOTH_OP;
        end
      end
      ST_DIV_SH: begin
        w_ctrl[CTRL_SHL] = 1'b1;
        w_next           = ST_DIV_OP;
      end
      ST_DIV_OP: begin
        w_ctrl[CTRL_ADD] = r_neg;
        w_ctrl[CTRL_SUB] = ~r_neg;
        w_next           = ST_DIV_SETQ;
      end
      ST_DIV_SETQ: begin
        w_ctrl[CTRL_SETQ0] = 1'b1;
        if (w_cnt_last) begin
          w_next = ST_DIV_CORR;
        end else begin
          w_cnt_inc = 1'b1;
          w_next    = ST_DIV_SH;
        end
      end
      ST_DIV_CORR: begin
        w_ctrl[CTRL_ADD] = a_msb;
        w_next           = ST_OUT_Q;
      end
      ST_OUT_A: begin
        // Multiply unloads A then Q; divide unloads Q then A.
        w_ctrl[CTRL_OUT_A] = 1'b1;
        w_next             = (r_op == OP_MUL) ? ST_OUT_Q : ST_DONE;
      end
      ST_OUT_Q: begin
        w_ctrl[CTRL_OUT_Q] = 1'b1;
        w_next             = (r_op == OP_DIV) ? ST_OUT_A : ST_DONE;
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_op    <= OP_ADD;
      r_neg   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && start) begin
        r_op  <= s;
        r_err <= 1'b0;
      end
      if (r_state == ST_CHECK && m_zero) begin
        r_err <= 1'b1;
      end
      // Sign of the partial remainder before the shift picks add or subtract.
      if (r_state == ST_DIV_SH) begin
        r_neg <= a_msb;
      end
    end
  end

  assign ctrl   = w_ctrl;
  assign busy   = (r_state != ST_IDLE);
  assign finish = (r_state == ST_DONE);
  assign err    = r_err;

endmodule

// File: tb/tb_alu_ctrl_param.sv
// tb/tb_alu_ctrl_param.sv - scoreboard bench for alu_ctrl_param driving a behavioural ALU datapath
module tb_alu_ctrl_param;
  import alu_ctrl_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  s = 2'b00;
  logic        q0, q_1, a_msb, m_zero;
  logic [8:0]  ctrl;
  logic        busy, finish, err;

  logic        start8 = 1'b0;
  logic [1:0]  s8 = 2'b00;
  logic [8:0]  ctrl8;
  logic        busy8, finish8, err8;

  alu_ctrl_param #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .s(s), .q0(q0), .q_1(q_1),
    .a_msb(a_msb), .m_zero(m_zero), .ctrl(ctrl), .busy(busy),
    .finish(finish), .err(err)
  );

  alu_ctrl_param #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .s(s8), .q0(1'b0), .q_1(1'b0),
    .a_msb(1'b0), .m_zero(1'b0), .ctrl(ctrl8), .busy(busy8),
    .finish(finish8), .err(err8)
  );

  // Datapath registers A (W+1), Q, M, Q_-1 as described for the surrounding ALU
  logic [W:0]   dp_a = '0;
  logic [W-1:0] dp_q = '0;
  logic [W-1:0] dp_m = 16'h0001;
  logic         dp_qm1 = 1'b0;
  logic [1:0]   dp_op = OP_ADD;
  logic [W-1:0] op_x = '0;
  logic [W-1:0] op_y = '0;
  logic [W-1:0] inbus, outbus;
  logic [W:0]   m_ext;

  assign inbus  = ctrl[CTRL_LD_X] ? op_x : op_y;
  assign m_ext  = (dp_op == OP_MUL) ? {dp_m[W-1], dp_m} : {1'b0, dp_m};
  assign outbus = ctrl[CTRL_OUT_A] ? dp_a[W-1:0] : dp_q;
  assign q0     = dp_q[0];
  assign q_1    = dp_qm1;
  assign a_msb  = dp_a[W];
  assign m_zero = (dp_m == '0);

  always @(posedge clk) begin
    if (ctrl[CTRL_LD_X]) begin
      dp_q   <= inbus;
      dp_a   <= '0;
      dp_qm1 <= 1'b0;
    end
    if (ctrl[CTRL_LD_Y]) dp_m <= inbus;
    if (ctrl[CTRL_ADD]) dp_a <= dp_a + m_ext;
    if (ctrl[CTRL_SUB]) dp_a <= dp_a - m_ext;
    if (ctrl[CTRL_SHR]) begin
      dp_a   <= {dp_a[W], dp_a[W:1]};
      dp_q   <= {dp_a[0], dp_q[W-1:1]};
      dp_qm1 <= dp_q[0];
    end
    if (ctrl[CTRL_SHL]) begin
      dp_a <= {dp_a[W-1:0], dp_q[W-1]};
      dp_q <= {dp_q[W-2:0], 1'b0};
    end
    if (ctrl[CTRL_SETQ0]) dp_q[0] <= ~dp_a[W];
  end

  // kind: 0 = OUT_A, 1 = OUT_Q, 2 = finish (val carries err)
  typedef struct {
    int           cyc;
    int           kind;
    logic [W-1:0] val;
  } ev_t;

  ev_t sb[$];
  int  n_vec = 0;
  int  n_fail = 0;
  int  c_add, c_sub, c_shr, c_shl, c_setq, c_out, fin_cyc;
  logic [8:0] ctrl_log [0:63];
  logic       busy_log [0:63];
  logic       err_log  [0:63];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int cyc, input int kind, input logic [W-1:0] val);
    ev_t e;
    e.cyc = cyc; e.kind = kind; e.val = val;
    sb.push_back(e);
  endtask

  task automatic sb_sample(input string nm, input int cyc);
    int           kind;
    logic [W-1:0] val;
    ev_t          e;
    kind = -1;
    val  = '0;
    if (ctrl[CTRL_OUT_A]) begin kind = 0; val = outbus; end
    else if (ctrl[CTRL_OUT_Q]) begin kind = 1; val = outbus; end
    else if (finish) begin kind = 2; val = {{(W-1){1'b0}}, err}; end
    if (kind >= 0) begin
      if (sb.size() == 0) begin
        check({nm, "_spurious_event"}, 32'(kind), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check({nm, "_event_cycle"}, 32'(cyc), 32'(e.cyc));
        check({nm, "_event_kind"}, 32'(kind), 32'(e.kind));
        check({nm, "_event_value"}, 32'(val), 32'(e.val));
      end
    end
  endtask

  task automatic run_op(input string nm, input logic [1:0] op, input logic [W-1:0] x,
                        input logic [W-1:0] y, input int budget, input int exp_fin);
    @(negedge clk);
    op_x = x; op_y = y; dp_op = op; s = op; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    s = ~op;
    c_add = 0; c_sub = 0; c_shr = 0; c_shl = 0; c_setq = 0; c_out = 0; fin_cyc = -1;
    for (int c = 1; c <= budget; c++) begin
      ctrl_log[c] = ctrl;
      busy_log[c] = busy;
      err_log[c]  = err;
      if (ctrl[CTRL_ADD]) c_add++;
      if (ctrl[CTRL_SUB]) c_sub++;
      if (ctrl[CTRL_SHR]) c_shr++;
      if (ctrl[CTRL_SHL]) c_shl++;
      if (ctrl[CTRL_SETQ0]) c_setq++;
      if (ctrl[CTRL_OUT_A] || ctrl[CTRL_OUT_Q]) c_out++;
      sb_sample(nm, c);
      if (finish) begin
        fin_cyc = c;
        break;
      end
      @(negedge clk);
    end
    check({nm, "_finish_cycle"}, 32'(fin_cyc), 32'(exp_fin));
    check({nm, "_sb_drained"}, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  // Integer model of non-restoring division: 1 when the final remainder needs correction
  function automatic int nr_corr(input int x, input int m);
    longint r;
    r = 0;
    for (int i = W - 1; i >= 0; i--) begin
      if (r >= 0) r = 2 * r + ((x >> i) & 1) - m;
      else        r = 2 * r + ((x >> i) & 1) + m;
    end
    return (r < 0) ? 1 : 0;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int corr, fin8, oa8, oq8, n8_shr, n8_other;

    repeat (2) @(negedge clk);
    check("rst_ctrl", 32'(ctrl), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_finish", 32'(finish), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy8", 32'(busy8), 32'd0);
    rst = 1'b0;

    // add: A is cleared by LD_X, so A+M unloads Y
    push(4, 0, 16'h0042); push(5, 2, 16'h0000);
    run_op("add", OP_ADD, 16'h1234, 16'h0042, 10, 5);
    check("add_c1", 32'(ctrl_log[1]), 32'h001);
    check("add_c2", 32'(ctrl_log[2]), 32'h002);
    check("add_c3", 32'(ctrl_log[3]), 32'h004);
    check("add_c4", 32'(ctrl_log[4]), 32'h080);
    for (int c = 1; c <= 5; c++) check("add_busy", 32'(busy_log[c]), 32'd1);

    push(4, 0, 16'hFFBE); push(5, 2, 16'h0000);
    run_op("sub", OP_SUB, 16'h1234, 16'h0042, 10, 5);
    check("sub_c3", 32'(ctrl_log[3]), 32'h008);

    // -3 * 7 = -21 -> A:Q = FFFF:FFEB
    push(35, 0, 16'hFFFF); push(36, 1, 16'hFFEB); push(37, 2, 16'h0000);
    run_op("mul", OP_MUL, 16'hFFFD, 16'h0007, 60, 37);
    check("mul_sub_count", 32'(c_sub), 32'd2);
    check("mul_add_count", 32'(c_add), 32'd1);
    check("mul_shr_count", 32'(c_shr), 32'd16);
    check("mul_shl_count", 32'(c_shl), 32'd0);
    check("mul_it0_sub", 32'(ctrl_log[3][CTRL_SUB]), 32'd1);
    check("mul_it1_add", 32'(ctrl_log[5][CTRL_ADD]), 32'd1);
    check("mul_it2_sub", 32'(ctrl_log[7][CTRL_SUB]), 32'd1);

    // 100 / 7 = 14 rem 2
    corr = nr_corr(100, 7);
    push(53, 1, 16'd14); push(54, 0, 16'd2); push(55, 2, 16'h0000);
    run_op("div", OP_DIV, 16'd100, 16'd7, 60, 55);
    check("div_shl_count", 32'(c_shl), 32'd16);
    check("div_setq_count", 32'(c_setq), 32'd16);
    check("div_addsub_count", 32'(c_add + c_sub), 32'(16 + corr));
    check("div_corr_add", 32'(ctrl_log[52][CTRL_ADD]), 32'(corr));
    check("div_corr_nosub", 32'(ctrl_log[52][CTRL_SUB]), 32'd0);

    push(4, 2, 16'h0001);
    run_op("divz", OP_DIV, 16'd100, 16'd0, 10, 4);
    check("divz_no_out", 32'(c_out), 32'd0);
    repeat (3) @(negedge clk);
    check("divz_err_held", 32'(err), 32'd1);
    push(4, 0, 16'h0005); push(5, 2, 16'h0000);
    run_op("add_after_err", OP_ADD, 16'h0001, 16'h0005, 10, 5);
    check("err_cleared_c1", 32'(err_log[1]), 32'd0);

    // reset in cycle 10 of a multiply, with start also high
    @(negedge clk);
    op_x = 16'h0123; op_y = 16'h0456; dp_op = OP_MUL; s = OP_MUL; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 10; c++) @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_ctrl", 32'(ctrl), 32'd0);
    check("mrst_finish", 32'(finish), 32'd0);
    rst = 1'b0; start = 1'b0;
    push(4, 0, 16'h0009); push(5, 2, 16'h0000);
    run_op("add_after_rst", OP_ADD, 16'h0003, 16'h0009, 10, 5);

    // WIDTH=8: start held high, s toggled every cycle during a multiply
    @(negedge clk);
    start8 = 1'b1; s8 = OP_MUL;
    @(negedge clk);
    n8_shr = 0; n8_other = 0; fin8 = -1; oa8 = -1; oq8 = -1;
    for (int c = 1; c <= 30; c++) begin
      if (ctrl8[CTRL_SHR]) n8_shr++;
      if (ctrl8[CTRL_ADD] | ctrl8[CTRL_SUB] | ctrl8[CTRL_SHL] | ctrl8[CTRL_SETQ0]) n8_other++;
      if (ctrl8[CTRL_OUT_A]) oa8 = c;
      if (ctrl8[CTRL_OUT_Q]) oq8 = c;
      if (finish8) begin
        fin8 = c;
        break;
      end
      s8 = 2'(c);
      @(negedge clk);
    end
    check("w8_finish_cycle", 32'(fin8), 32'd21);
    check("w8_shr_count", 32'(n8_shr), 32'd8);
    check("w8_other_strobes", 32'(n8_other), 32'd0);
    check("w8_out_a_cycle", 32'(oa8), 32'd19);
    check("w8_out_q_cycle", 32'(oq8), 32'd20);
    s8 = OP_ADD;
    @(negedge clk);
    check("w8_idle_after_done", 32'(busy8), 32'd0);
    @(negedge clk);
    check("w8_new_ldx", 32'(ctrl8), 32'h001);
    start8 = 1'b0; s8 = OP_DIV;
    @(negedge clk);
    check("w8_new_ldy", 32'(ctrl8), 32'h002);
    @(negedge clk);
    check("w8_new_exec_add", 32'(ctrl8), 32'h004);
    repeat (2) @(negedge clk);
    check("w8_new_finish", 32'(finish8), 32'd1);
    check("w8_err", 32'(err8), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_param.md
# alu_ctrl_param

Parametrised control unit for the WIDTH-bit add/sub/multiply/divide ALU. It sequences the datapath through operand load, execution, result unload and completion. Multiply uses radix-2 Booth; divide is non-restoring with a final remainder correction. It adds an internal iteration counter, an op latch, a busy/finish handshake and divide-by-zero detection. It sits between the ALU datapath registers (A is WIDTH+1 bits, Q and M are WIDTH bits, Q_-1 is 1 bit) and the surrounding processor sequencer.

## Interface
- WIDTH, 16: operand width; legal values are ≥4.
- CNT_W, $clog2(WIDTH): iteration counter width.

- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request a new operation; sampled only in IDLE.
- s  in  2  opcode: 00 add, 01 sub, 10 mul, 11 div; latched when start is accepted.
- q0  in  1  Q[0], used for Booth recoding.
- q_1  in  1  Q_-1, used for Booth recoding.
- a_msb  in  1  A[WIDTH], the sign of the partial remainder.
- m_zero  in  1  asserted when M == 0.
- ctrl  out  9  datapath strobes, listed below.
  - [0] LD_X: Q ← inbus; clear A and Q_-1.
  - [1] LD_Y: M ← inbus.
  - [2] ADD: A ← A+M.
  - [3] SUB: A ← A−M.
  - [4] SHR: arithmetic right shift of {A,Q,Q_-1}.
  - [5] SHL: left shift of {A,Q}.
  - [6] SETQ0: Q[0] ← ~a_msb.
  - [7] OUT_A: drive A onto outbus.
  - [8] OUT_Q: drive Q onto outbus.
- busy  out  1  high whenever state ≠ IDLE.
- finish  out  1  one-cycle pulse in DONE.
- err  out  1  divide-by-zero flag.

## Operation
- States (4-bit register): IDLE, LOAD_X, LOAD_Y, CHECK, EXEC, BOOTH_OP, BOOTH_SH, DIV_SH, DIV_OP, DIV_SETQ, DIV_CORR, OUT_A, OUT_Q, DONE.
- IDLE
  - With start=1: op_r ← s, err ← 0, go to LOAD_X.
  - Otherwise stay in IDLE.
  - start asserted in any other state is ignored.
- LOAD_X asserts LD_X, then goes to LOAD_Y.
- LOAD_Y asserts LD_Y and clears cnt. Next state by op:
  - add/sub → EXEC.
  - mul → BOOTH_OP.
  - div → CHECK.
- EXEC asserts ADD for op 00 or SUB for op 01, then goes to OUT_A.
- BOOTH_OP
  - {q0,q_1}=01 → ADD; 10 → SUB; 00 or 11 → no strobe.
  - Next state is BOOTH_SH.
- BOOTH_SH asserts SHR.
  - If cnt == WIDTH−1 → OUT_A.
  - Otherwise cnt+1 and return to BOOTH_OP.
- CHECK asserts no strobe.
  - m_zero=1 → err ← 1, go to DONE.
  - Otherwise go to DIV_SH.
- DIV_SH asserts SHL; neg_r ← a_msb (the value before the shift); go to DIV_OP.
- DIV_OP asserts SUB if neg_r=0, ADD if neg_r=1; go to DIV_SETQ.
- DIV_SETQ asserts SETQ0.
  - If cnt == WIDTH−1 → DIV_CORR.
  - Otherwise cnt+1 and return to DIV_SH.
- DIV_CORR asserts ADD iff a_msb=1; next state is OUT_Q.
- Unload order:
  - add/sub: OUT_A → DONE.
  - mul: OUT_A (high half) → OUT_Q (low half) → DONE.
  - div: OUT_Q (quotient) → OUT_A (remainder) → DONE.
- DONE asserts finish, then goes to IDLE.
- err holds its value until the next accepted start.
- Strobes are Mealy: decoded from state, op_r, q0, q_1, neg_r and a_msb. At most one of ADD/SUB is high, and at most one of OUT_A/OUT_Q is high.
- Unreachable state encodings → IDLE on the next edge, all strobes 0.

## Timing
- Reset: on the edge with rst=1:
  - state ← IDLE; cnt, op_r, neg_r and err ← 0.
  - ctrl=0, busy=0, finish=0 in the following cycle.
- Reset mid-operation behaves identically and overrides start.
- Cycle 0 is the cycle in which start is sampled high in IDLE. LOAD_X is cycle 1. finish is high in cycle:
  - add/sub: 5.
  - mul: 2·WIDTH+5 (37 at WIDTH=16).
  - div: 3·WIDTH+7 (55 at WIDTH=16).
  - div by zero: 4.
- start may be asserted in the cycle immediately after DONE (back-to-back). That cycle is IDLE, so the earliest new LOAD_X is 2 cycles after DONE.
- Counter wrap never occurs: the loop exits at WIDTH−1.
- s changing while busy has no effect.

## Structure
- Shared package alu_ctrl_pkg holds:
  - state enum (4-bit);
  - opcode constants OP_ADD/OP_SUB/OP_MUL/OP_DIV;
  - ctrl bit index constants CTRL_LD_X … CTRL_OUT_Q.
- Sub-module alu_iter_counter holds the CNT_W-bit counter.
  - Inputs: clr, inc.
  - Output: last = (cnt == WIDTH−1).
  - Reset is synchronous.
- The state register, next-state logic and strobe decode live in alu_ctrl_param.

## Test plan
- Add, WIDTH=16, s=00, start pulse:
  - Strobes LD_X, LD_Y, ADD, OUT_A in cycles 1–4.
  - finish in cycle 5; err=0; busy high in cycles 1–5.
- Mul, s=10, X=0xFFFD, Y=7, q0/q_1 from a reference shift model:
  - Exactly 2 SUB pulses (iterations 0 and 2) and 1 ADD pulse (iteration 1).
  - 16 SHR pulses.
  - OUT_A in cycle 35, OUT_Q in cycle 36, finish in cycle 37.
- Div, s=11, dividend 100, divisor 7, a_msb from a reference model:
  - 16 each of SHL, SETQ0 and ADD/SUB.
  - DIV_CORR ADD only if the model's remainder is negative.
  - OUT_Q in cycle 53, OUT_A in cycle 54, finish in cycle 55.
- Div by zero, m_zero=1:
  - finish in cycle 4 with err=1; no OUT strobes.
  - err stays 1 until the next start, then clears.
- rst=1 in cycle 10 of a multiply:
  - Next cycle: IDLE, ctrl=0, busy=0.
  - A subsequent add completes in 5 cycles.
- WIDTH=8 instance, start held high for the whole mul and s toggled mid-operation:
  - Op stays mul; finish in cycle 21.
  - A new operation starts only from IDLE.
